fifo_pixel_reader: RTL and testbench

Single-clock read-side master for the pixel FIFO. It drains one frame of IMG_W×IMG_H pixels from the FIFO read port (rd_en / rd_ack handshake) and presents them as a valid/ready pixel stream with start-of-frame, end-of-line and end-of-frame markers. It sits on the consumer clock domain, between the FIFO's read side and the downstream image-processing pipeline.

---
 rtl/fifo_pixel_reader_pkg.sv | 17 +
 rtl/fifo_pixel_reader_skid_buf2.sv | 52 +++++
 rtl/fifo_pixel_reader.sv | 144 ++++++++++++++
 tb/tb_fifo_pixel_reader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pixel_reader_pkg.sv
// Shared types and helpers for the pixel FIFO read-side master.
package fifo_pixel_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } rd_state_t;

  // Reads in flight plus pixels parked in the output buffer may never exceed this.
  localparam int CREDITS = 2;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_pixel_reader_skid_buf2.sv
// Two-entry registered FIFO; push lands one cycle later, pop is combinational from the head.
// A push into a full buffer is accepted only when a pop frees the head in the same cycle.
module fifo_pixel_reader_skid_buf2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [1:0]        count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_pixel_reader.sv
// Drains one IMG_W x IMG_H frame from the pixel FIFO into a valid/ready stream with sof/eol/eof.
// Reads are issued only while reads in flight plus buffered pixels stay below two, so m_ready stalls never drop data.
module fifo_pixel_reader
  import fifo_pixel_reader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  input  logic              fifo_rd_ack,
  input  logic              fifo_empty,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sof,
  output logic              m_eol,
  output logic              m_eof
);

  localparam int FRAME_PIX = IMG_W * IMG_H;
  localparam int REQ_W     = $clog2(FRAME_PIX + 1);
  localparam int COL_W     = cnt_w(IMG_W);
  localparam int ROW_W     = cnt_w(IMG_H);

  localparam logic [REQ_W-1:0] REQ_FULL = REQ_W'(FRAME_PIX);
  localparam logic [REQ_W-1:0] REQ_LAST = REQ_W'(FRAME_PIX - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [2:0]       CRED_MAX = 3'(CREDITS);

  rd_state_t         state;
  logic [REQ_W-1:0]  req_cnt;
  logic [1:0]        outs;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;

  logic [1:0]        buf_count;
  logic              buf_full;
  logic              buf_empty;
  logic [DATA_W-1:0] buf_data;
  logic [2:0]        credit_used;
  logic              ack_ok;
  logic              accept;

  assign credit_used = {1'b0, outs} + {1'b0, buf_count};
  // fifo_empty is looked at in the issue cycle itself, so a read never goes out against an empty FIFO.
  assign fifo_rd_en  = (state == ST_STREAM) && !fifo_empty && (req_cnt < REQ_FULL)
                       && !buf_full && (credit_used < CRED_MAX);

  // An ack with nothing in flight carries no pixel of ours; it is dropped and flagged.
  assign ack_ok  = fifo_rd_ack && (outs != 2'd0);

  assign m_valid = !buf_empty;
  assign m_data  = buf_data;
  assign accept  = m_valid && m_ready;
  assign m_sof   = m_valid && (col == '0) && (row == '0);
  assign m_eol   = m_valid && (col == COL_LAST);
  assign m_eof   = m_eol && (row == ROW_LAST);
  assign busy    = (state != ST_IDLE);

  fifo_pixel_reader_skid_buf2 #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .aresetn   (aresetn),
    .push      (ack_ok),
    .push_data (fifo_rd_data),
    .pop       (accept),
    .pop_data  (buf_data),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= ST_IDLE;
      req_cnt <= '0;
      outs    <= 2'd0;
      col     <= '0;
      row     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;

      if (fifo_rd_ack && (outs == 2'd0)) begin
        err <= 1'b1;
      end

      case ({fifo_rd_en, ack_ok})
        2'b10:   outs <= outs + 2'd1;
        2'b01:   outs <= outs - 2'd1;
        default: outs <= outs;
      endcase

      if (fifo_rd_en) begin
        req_cnt <= req_cnt + 1'b1;
      end

      if (accept) begin
        if (m_eol) begin
          col <= '0;
          row <= m_eof ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_STREAM;
            req_cnt <= '0;
            col     <= '0;
            row     <= '0;
          end
        end
        ST_STREAM: begin
          if (fifo_rd_en && (req_cnt == REQ_LAST)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The eof beat leaving an otherwise empty pipe closes the frame.
          if (accept && m_eof && (outs == 2'd0) && (buf_count == 2'd1)) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pixel_reader.sv
// Randomized bench for fifo_pixel_reader: an upstream FIFO/ack model plus a queue-based reference of the reader.
module tb_fifo_pixel_reader;

  localparam int DW    = 8;
  localparam int W     = 4;
  localparam int H     = 2;
  localparam int FRAME = W * H;

  logic          clk          = 1'b0;
  logic          aresetn      = 1'b0;
  logic          start        = 1'b0;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_ack  = 1'b0;
  logic          fifo_empty   = 1'b1;
  logic          m_ready      = 1'b0;
  logic          busy, done, err, fifo_rd_en, m_valid, m_sof, m_eol, m_eof;
  logic [DW-1:0] m_data;

  always #5 clk = ~clk;

  fifo_pixel_reader #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_ack  (fifo_rd_ack),
    .fifo_empty   (fifo_empty),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_sof        (m_sof),
    .m_eol        (m_eol),
    .m_eof        (m_eof)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Upstream FIFO contents and the acks promised for issued reads.
  int fifo_q[$];
  int ack_t[$];
  int ack_d[$];
  int last_ack = -1;

  // Reference reader: pixels delivered but not yet accepted, plus frame bookkeeping.
  int ref_q[$];
  bit ref_busy, ref_done, ref_err;
  int ref_outs, ref_req, ref_beats;
  bit exp_rd, exp_vld;

  int ready_mode = 0, lat_max = 1;
  bit force_empty = 0, start_req = 0, inject_ack = 0;

  int log_d[$];
  int log_mk[$];
  int dut_rd_cnt, done_cnt, done_cyc, last_acc_cyc, rd_in_gap;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic compare();
    int c, r;
    exp_vld = ref_q.size() > 0;
    exp_rd  = ref_busy && !fifo_empty && (ref_req < FRAME) && ((ref_outs + ref_q.size()) < 2);
    c = ref_beats % W;
    r = ref_beats / W;
    chk("fifo_rd_en", fifo_rd_en, exp_rd);
    chk("m_valid", m_valid, exp_vld);
    if (exp_vld) chk("m_data", m_data, ref_q[0]);
    chk("m_sof", m_sof, exp_vld && c == 0 && r == 0);
    chk("m_eol", m_eol, exp_vld && c == W - 1);
    chk("m_eof", m_eof, exp_vld && c == W - 1 && r == H - 1);
    chk("busy", busy, ref_busy);
    chk("done", done, ref_done);
    chk("err", err, ref_err);
  endtask

  task automatic update();
    int old_outs, v, t;
    bit was_busy, ack_good;
    old_outs = ref_outs;
    was_busy = ref_busy;
    ref_done = 0;
    if (fifo_rd_en) dut_rd_cnt++;
    if (fifo_rd_en && force_empty) rd_in_gap++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (m_valid && m_ready) begin
      log_d.push_back(int'(m_data));
      log_mk.push_back(int'({m_sof, m_eol, m_eof}));
      last_acc_cyc = cyc;
    end
    if (exp_rd) begin
      v = fifo_q.pop_front();
      t = cyc + int'($urandom_range(1, lat_max));
      if (t <= last_ack) t = last_ack + 1;
      ack_t.push_back(t);
      ack_d.push_back(v);
      last_ack = t;
      ref_req++;
    end
    ack_good = fifo_rd_ack && old_outs > 0;
    if (fifo_rd_ack && old_outs == 0) ref_err = 1;
    if (exp_vld && m_ready) begin
      void'(ref_q.pop_front());
      ref_beats++;
      if (ref_beats == FRAME) begin ref_busy = 0; ref_done = 1; end
    end
    if (ack_good) ref_q.push_back(int'(fifo_rd_data));
    ref_outs = old_outs + (exp_rd ? 1 : 0) - (ack_good ? 1 : 0);
    if (start && !was_busy) begin ref_busy = 1; ref_req = 0; ref_beats = 0; end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    fifo_empty   = force_empty || fifo_q.size() == 0;
    fifo_rd_ack  = 1'b0;
    fifo_rd_data = '0;
    if (ack_t.size() > 0 && ack_t[0] == cyc) begin
      fifo_rd_ack  = 1'b1;
      fifo_rd_data = DW'(ack_d[0]);
      void'(ack_t.pop_front());
      void'(ack_d.pop_front());
    end else if (inject_ack) begin
      fifo_rd_ack  = 1'b1;
      fifo_rd_data = 8'hEE;
    end
    inject_ack = 0;
    start      = start_req;
    start_req  = 0;
    #1;
    compare();
    update();
  endtask

  task automatic do_reset();
    @(negedge clk);
    aresetn = 1'b0; start = 1'b0; fifo_rd_ack = 1'b0; fifo_rd_data = '0;
    m_ready = 1'b0; fifo_empty = 1'b1; force_empty = 0;
    @(posedge clk);
    #1;
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_markers", {m_sof, m_eol, m_eof}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    ref_q.delete(); ack_t.delete(); ack_d.delete(); fifo_q.delete();
    last_ack = cyc;
    ref_busy = 0; ref_done = 0; ref_err = 0;
    ref_outs = 0; ref_req = 0; ref_beats = 0;
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  task automatic run_frame(input int rmode, input int lmax, input bit seq,
                           input int gap_beat, input int restart_beat, input int abort_beat);
    int n, gap_left;
    bit gap_fired, restart_fired;
    fifo_q.delete();
    for (int i = 0; i < FRAME; i++) fifo_q.push_back(seq ? i : int'($urandom_range(0, 255)));
    log_d.delete(); log_mk.delete();
    dut_rd_cnt = 0; done_cnt = 0; done_cyc = -1; last_acc_cyc = -1; rd_in_gap = 0;
    ready_mode = rmode; lat_max = lmax; start_req = 1;
    n = 0; gap_left = 0; gap_fired = 0; restart_fired = 0;
    while (n < 600) begin
      if (abort_beat >= 0 && log_d.size() >= abort_beat) return;
      if (gap_beat >= 0 && !gap_fired && log_d.size() >= gap_beat) begin
        gap_fired = 1; gap_left = 10;
      end
      force_empty = gap_left > 0;
      if (gap_left > 0) gap_left--;
      if (restart_beat >= 0 && !restart_fired && log_d.size() >= restart_beat) begin
        restart_fired = 1; start_req = 1;
      end
      step();
      n++;
      if (ref_done) begin
        step();
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL frame_timeout: got %0d beats after %0d cycles, required %0d", log_d.size(), n, FRAME);
  endtask

  initial begin
    do_reset();

    // In-order frame, ack latency 1, always ready.
    run_frame(0, 1, 1, -1, -1, -1);
    chk("s1_beats", log_d.size(), FRAME);
    for (int i = 0; i < FRAME && i < log_d.size(); i++) begin
      chk("s1_data", log_d[i], i);
      chk("s1_markers", log_mk[i], {i == 0, (i % W) == W - 1, i == FRAME - 1});
    end
    chk("s1_done_lat", done_cyc - last_acc_cyc, 1);
    chk("s1_done_cnt", done_cnt, 1);

    // Downstream stalls 1,0,0,1 with varying ack latency.
    run_frame(1, 3, 0, -1, -1, -1);
    chk("s2_beats", log_d.size(), FRAME);
    chk("s2_reads", dut_rd_cnt, FRAME);

    // FIFO reports empty for 10 cycles mid-frame.
    run_frame(0, 2, 0, 3, -1, -1);
    chk("s3_gap_reads", rd_in_gap, 0);
    chk("s3_beats", log_d.size(), FRAME);
    for (int i = 0; i < FRAME && i < log_mk.size(); i++)
      chk("s3_markers", log_mk[i], {i == 0, (i % W) == W - 1, i == FRAME - 1});

    // Unsolicited ack while idle.
    inject_ack = 1;
    step();
    step();
    chk("s4_err", err, 1);
    chk("s4_no_valid", m_valid, 0);
    step();
    chk("s4_err_sticky", err, 1);

    // Reset after three beats, then a full fresh frame.
    run_frame(2, 2, 0, -1, -1, 3);
    do_reset();
    run_frame(0, 1, 1, -1, -1, -1);
    chk("s5_beats", log_d.size(), FRAME);
    if (log_d.size() > 0) begin
      chk("s5_first_data", log_d[0], 0);
      chk("s5_first_sof", log_mk[0], 3'b100);
    end

    // start pulsed while busy.
    run_frame(1, 2, 0, -1, 2, -1);
    chk("s6_reads", dut_rd_cnt, FRAME);
    chk("s6_done_cnt", done_cnt, 1);

    // Random ready and latency.
    for (int k = 0; k < 4; k++) begin
      run_frame(2, 3, 0, -1, -1, -1);
      chk("s7_beats", log_d.size(), FRAME);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
